// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_pkg
// Purpose  : Shared definitions for the branch-condition evaluator:
//            in_cond field positions, selector codes, the S1->S2 compare
//            payload and the resolve function used by the second stage.
// Revision : 1.0 - initial release
// ============================================================================
package cond_pkg;

    // Bit positions inside the 4-bit condition code
    localparam int NEG    = 3;  // invert the selected relation
    localparam int ZERO   = 2;  // compare A against zero instead of B
    localparam int SEL_HI = 1;
    localparam int SEL_LO = 0;

    // Relation selector, in_cond[SEL_HI:SEL_LO]
    localparam logic [1:0] COND_F   = 2'b00;
    localparam logic [1:0] COND_EQ  = 2'b01;
    localparam logic [1:0] COND_LT  = 2'b10;
    localparam logic [1:0] COND_LTE = 2'b11;

    // Compare result carried from S1 to S2. The ZERO bit has already been
    // consumed when selecting b_eff, so only NEG and the selector travel on.
    typedef struct packed {
        logic       eq;
        logic       lt;
        logic       neg;
        logic [1:0] sel;
        logic       pred;
    } cmp_core_t;

    function automatic logic cond_taken(input logic neg, input logic [1:0] sel,
                                        input logic eq, input logic lt);
        logic c;
        case (sel)
            COND_F:  c = 1'b0;
            COND_EQ: c = eq;
            COND_LT: c = lt;
            default: c = eq | lt;
        endcase
        return neg ^ c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_cmp.sv
`default_nettype none
// ============================================================================
// Module   : cond_cmp
// Purpose  : Combinational signed compare of a against b.
// Ports    : a, b [DBITS]  operands (two's complement)
//            eq            a == b
//            lt            a <  b (signed, exact under overflow)
// Revision : 1.0 - initial release
// ============================================================================
module cond_cmp #(
    parameter int DBITS = 32
) (
    input  logic [DBITS-1:0] a,
    input  logic [DBITS-1:0] b,
    output logic             eq,
    output logic             lt
);

    // One extra bit keeps the signed difference exact, so its sign bit is
    // the true less-than even when a DBITS-wide subtract would overflow.
    logic [DBITS:0] w_diff;

    assign w_diff = {a[DBITS-1], a} - {b[DBITS-1], b};
    assign lt     = w_diff[DBITS];
    // Low DBITS bits are zero exactly when a == b (difference modulo 2^DBITS)
    assign eq     = (w_diff[DBITS-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/cond_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval_pipe
// Purpose  : Two-stage pipelined branch-condition evaluator. S1 registers the
//            signed compare of in_a against in_b (or zero); S2 resolves
//            taken / mispredict and drives all outputs from registers.
// Ports    : clk, reset_n (async, active-low), flush
//            in_valid/in_ready, in_cond[4], in_a/in_b[DBITS], in_pred,
//            in_tag[TAG_BITS]
//            out_valid/out_ready, out_taken, out_mispred, out_tag[TAG_BITS]
//            COND_STATS_EN adds: stat_clear, stat_branches[CNT_BITS],
//            stat_mispreds[CNT_BITS] and the CNT_BITS parameter.
// Revision : 1.0 - initial release
// ============================================================================
module cond_eval_pipe
    import cond_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int TAG_BITS = 4
`ifdef COND_STATS_EN
    ,
    parameter int CNT_BITS = 16
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_cond,
    input  logic [DBITS-1:0]    in_a,
    input  logic [DBITS-1:0]    in_b,
    input  logic                in_pred,
    input  logic [TAG_BITS-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_taken,
    output logic                out_mispred,
    output logic [TAG_BITS-1:0] out_tag
`ifdef COND_STATS_EN
    ,
    input  logic                stat_clear,
    output logic [CNT_BITS-1:0] stat_branches,
    output logic [CNT_BITS-1:0] stat_mispreds
`endif
);

    typedef struct packed {
        cmp_core_t           core;
        logic [TAG_BITS-1:0] tag;
    } s1_entry_t;

    logic                r_live;        // low in reset so in_ready stays 0
    logic                r_s1_valid;
    s1_entry_t           r_s1;
    logic                r_s2_valid;
    logic                r_s2_taken;
    logic                r_s2_mispred;
    logic [TAG_BITS-1:0] r_s2_tag;

    logic [DBITS-1:0]    w_b_eff;
    logic                w_eq;
    logic                w_lt;
    logic                w_s2_adv;
    logic                w_s1_adv;
    logic                w_accept;
    logic                w_taken;
    s1_entry_t           w_s1_next;

    // ---------------- S1: compare ----------------
    assign w_b_eff = in_cond[ZERO] ? '0 : in_b;

    cond_cmp #(.DBITS(DBITS)) u_cmp (
        .a  (in_a),
        .b  (w_b_eff),
        .eq (w_eq),
        .lt (w_lt)
    );

    always_comb begin
        w_s1_next           = '0;
        w_s1_next.core.eq   = w_eq;
        w_s1_next.core.lt   = w_lt;
        w_s1_next.core.neg  = in_cond[NEG];
        w_s1_next.core.sel  = in_cond[SEL_HI:SEL_LO];
        w_s1_next.core.pred = in_pred;
        w_s1_next.tag       = in_tag;
    end

    // ---------------- handshake ----------------
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = r_live && w_s1_adv;
    // Flush kills a concurrent request even when in_ready is high
    assign w_accept = in_valid && in_ready && !flush;

    // ---------------- S2: resolve ----------------
    assign w_taken = cond_taken(r_s1.core.neg, r_s1.core.sel, r_s1.core.eq, r_s1.core.lt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live       <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1         <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_taken   <= 1'b0;
            r_s2_mispred <= 1'b0;
            r_s2_tag     <= '0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (w_s2_adv) r_s2_valid <= r_s1_valid;
                if (w_s1_adv) r_s1_valid <= w_accept;
            end
            // S2 data only changes when a real entry moves in, so the
            // outputs hold steady under backpressure.
            if (!flush && w_s2_adv && r_s1_valid) begin
                r_s2_taken   <= w_taken;
                r_s2_mispred <= w_taken ^ r_s1.core.pred;
                r_s2_tag     <= r_s1.tag;
            end
            if (w_accept) r_s1 <= w_s1_next;
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_taken   = r_s2_taken;
    assign out_mispred = r_s2_mispred;
    assign out_tag     = r_s2_tag;

`ifdef COND_STATS_EN
    // ---------------- statistics ----------------
    logic [CNT_BITS-1:0] r_branches;
    logic [CNT_BITS-1:0] r_mispreds;
    logic                w_xfer;

    assign w_xfer = r_s2_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_branches <= '0;
            r_mispreds <= '0;
        end else if (stat_clear) begin
            r_branches <= '0;
            r_mispreds <= '0;
        end else begin
            if (w_xfer && (r_branches != '1))
                r_branches <= r_branches + CNT_BITS'(1);
            if (w_xfer && r_s2_mispred && (r_mispreds != '1))
                r_mispreds <= r_mispreds + CNT_BITS'(1);
        end
    end

    assign stat_branches = r_branches;
    assign stat_mispreds = r_mispreds;
`endif

endmodule
`default_nettype wire

// File: doc/cond_eval_pipe.md
Name: cond_eval_pipe

Overview:
- Pipelined, parametrised branch-condition evaluator and the successor to the single-cycle condition checker.
- Takes two operands plus the 4-bit condition code and computes the compare internally with overflow-safe signed arithmetic.
- Resolves taken/not-taken, compares the result against the fetch-stage prediction and flags mispredicts.
- Sits between the execute stage and branch redirect logic, using a valid/ready handshake with flush.

Parameters:
DBITS, 32, operand width (>=2)
TAG_BITS, 4, width of the opaque instruction tag carried alongside each request
CNT_BITS, 16, statistics counter width (used only with COND_STATS_EN)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all in-flight entries
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
in_cond  input  4  condition code (encoding below)
in_a  input  DBITS  operand A
in_b  input  DBITS  operand B (ignored for zero-compare codes)
in_pred  input  1  predicted taken
in_tag  input  TAG_BITS  request tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_taken  output  1  resolved branch outcome
out_mispred  output  1  out_taken != predicted
out_tag  output  TAG_BITS  tag of the result

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. While reset_n=0, all valid bits, out_taken, out_mispred and out_tag are 0 and in_ready is 0. in_ready goes to 1 on the first clk edge after release.
- Condition encoding:
  - in_cond[1:0]: 00 false, 01 EQ, 10 LT, 11 LTE.
  - in_cond[2]=1: compare A against zero; B is replaced by 0 inside the block.
  - in_cond[3]=1: invert the result, giving T/NE/GTE/GT.
- S1 (compare), on an accepted request:
  - b_eff = in_cond[2] ? 0 : in_b.
  - Compute diff = sext(in_a) - sext(b_eff) at DBITS+1 bits.
  - Register eq=(in_a==b_eff), lt=diff[DBITS], plus cond, pred and tag.
  - LT must be correct at signed overflow: -2^(DBITS-1) < 1 is true.
- S2 (resolve):
  - c = sel(cond[1:0]; 0, eq, lt, eq|lt).
  - taken = cond[3] ^ c.
  - mispred = taken ^ pred.
  - All outputs are driven from registers; no combinational path from any in_* signal to any out_* signal.
- Latency and throughput: 2 cycles from an accept edge to out_valid. Sustains 1 request per cycle when out_ready=1.
- Handshake:
  - Accept when in_valid & in_ready.
  - S2 may advance when !s2_valid | out_ready.
  - in_ready = !s1_valid | (S2 may advance).
  - While out_valid=1 and out_ready=0, out_taken, out_mispred and out_tag hold stable.
  - When both stages are full under backpressure, in_ready=0 and no data is lost or reordered.
- Flush:
  - On a flush=1 edge, s1_valid and s2_valid are cleared.
  - A request presented in the same cycle is discarded, even if in_ready=1.
  - An out_valid&out_ready transfer in the flush cycle still completes; the consumer decides.
  - Flush has priority over accept.
- Simultaneous events: S2 drain and S1 refill in the same cycle are legal and lose no bubble.

Optional Feature:
COND_STATS_EN
- Defined:
  - Adds outputs stat_branches[CNT_BITS-1:0] and stat_mispreds[CNT_BITS-1:0], plus input stat_clear.
  - Counters increment on each out_valid&out_ready transfer; the mispred counter only when out_mispred=1.
  - Counters saturate at all-ones and do not wrap.
  - stat_clear synchronously zeroes both counters and wins over an increment in the same cycle.
  - Both counters are reset to 0 by reset_n.
  - flush does not affect the counters.
- Undefined: the stats ports and logic are absent; the core behaviour is identical.

Decomposition:
- Shared package cond_pkg:
  - localparams for the in_cond field positions (NEG=3, ZERO=2, SEL=1:0).
  - Named selector codes COND_F, COND_EQ, COND_LT, COND_LTE.
  - A packed struct for the S1->S2 payload (eq, lt, cond, pred, tag).
- One natural sub-module, cond_cmp: the combinational S1 compare producing eq/lt from a, b_eff.

Test Plan:
1. DBITS=32, cond=0010 (LT), a=0x80000000, b=1, pred=0 -> two cycles later out_valid=1, taken=1, mispred=1, tag echoed.
2. Back-to-back stream of 8 requests with out_ready=1: EQZ a=0, NE a=b=5, GTEZ a=-1, GT a=3 b=2, etc. -> one result per cycle, in order, taken = 1,0,0,1 for the first four.
3. out_ready held 0 for 5 cycles while 4 requests are offered -> exactly 2 accepted, in_ready=0 afterward, outputs stable; on release the results drain in order.
4. flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0, nothing from the flushed or concurrent request emerges later.
5. reset_n dropped mid-stream (asynchronously, between edges) -> out_valid, out_taken and out_mispred go to 0 immediately, in_ready=0; the first post-release request resolves normally.
6. COND_STATS_EN with CNT_BITS=4: 17 mispredicting transfers -> stat_mispreds=15 (saturated); stat_clear concurrent with a transfer -> 0.
